vga_timing_gen_p: RTL and testbench
===================================

// Module: vga_timing_gen_p
// PURPOSE
//  Parametrised VGA timing/scan engine, successor of the fixed 640x480 interface.
//  Generates h/v counters, sync and blank, and framebuffer read addresses, with
//  optional integer pixel replication (2^SCALE_LOG2 square blocks) and a pixel
//  clock enable. Sits between the framebuffer RAM (RD_LAT read latency) and the DAC.
//  Compensates RD_LAT internally so colour, sync and blank leave aligned.
// PARAMETERS
//  H_DISPLAY 640 | H_FRONT 16 | H_SYNC 96 | H_BACK 48   : horizontal timing, pixels
//  V_DISPLAY 480 | V_FRONT 10 | V_SYNC 2  | V_BACK 33   : vertical timing, lines
//  HS_POL 0, VS_POL 0 : active sync level (0 = active low)
//  SCALE_LOG2 0       : replication; FB_W = H_DISPLAY>>S, FB_H = V_DISPLAY>>S (0..3)
//  RD_LAT 1           : clk-enable steps from oAddress to matching R_in/G_in/B_in (1..4)
//  COLOR_W 8, ADDR_W 19, CNT_W 10 : colour, address and counter widths
// PORTS
//  clk        in  1        pixel/system clock
//  rst        in  1        synchronous, active-high reset
//  en         in  1        pixel enable; all state advances only when en=1
//  R_in,G_in,B_in in COLOR_W  framebuffer data, valid RD_LAT steps after its address
//  oAddress   out ADDR_W   framebuffer read address (registered)
//  R,G,B      out COLOR_W  colour to DAC, 0 while blanked (registered)
//  HS,VS      out 1        syncs at HS_POL/VS_POL (registered, aligned to colour)
//  BLANK_N    out 1        1 in active video (registered, aligned to colour)
//  VGA_SYNC   out 1        constant 1;  VGA_CLK out 1 = clk
//  h_pos,v_pos out CNT_W   raw scan counters (stage 0, not delayed)
//  frame_start out 1       1 for one en-step when counters = (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of H_*, V_TOTAL = sum of V_*. Line order: sync, back, display, front.
//  - Counters: on en, h_pos++; at H_TOTAL-1 -> 0 and v_pos++ (V_TOTAL-1 -> 0). en=0: hold all.
//  - Active (stage 0): H_SYNC+H_BACK <= h_pos < H_SYNC+H_BACK+H_DISPLAY, same form for v.
//  - Address: x = h_pos-H_ACT_START, y = v_pos-V_ACT_START. oAddress <= line_base + (x>>S)
//    on en when active; held when not active. No multiplier: line_base register is 0 at
//    (0,0); at end of each active line with (y & (2^S-1)) == 2^S-1, line_base += FB_W.
//  - Address sequence per frame: 0..FB_W*FB_H-1, each repeated 2^S per line, each row
//    2^S lines; wraps to 0 next frame; never exceeds FB_W*FB_H-1.
//  - Pipeline: active/HS/VS delayed 1+RD_LAT en-steps in shift registers, then output
//    register samples R_in etc. Total latency L = 2+RD_LAT en-steps counter->outputs.
//  - Output reg: BLANK_N=1 -> RGB = inputs; BLANK_N=0 -> RGB = 0.
//  - Reset (any cycle, overrides en): h_pos=v_pos=0, oAddress=0, line_base=0, delay lines
//    cleared (inactive), R=G=B=0, BLANK_N=0, HS=~HS_POL, VS=~VS_POL, frame_start=0.
//    Mid-frame reset restarts frame at (0,0); first sync pulse appears L steps after release.
//  - frame_start is combinational from counters AND en; 0 during rst.
// TESTING
//  1 Defaults, en=1, release rst: HS active 96 clk per 800, VS active 1600 clk per
//    420000; first HS edge at clk L=3 after release; BLANK_N high 640 clk per active line.
//  2 Defaults: first oAddress=0 at (h=144,v=35); 640 distinct per line; last 307199 at
//    (783,514); holds 307199 through blank; 0 on first pixel of next frame.
//  3 SCALE_LOG2=1: line 35 = 0,0,1,1..319,319; line 36 repeats; line 37 starts 320;
//    last address 76799.
//  4 RD_LAT=2, model RAM returns R_in = addr[7:0] after 2 steps: R on first BLANK_N=1
//    clk = 0, next = 1; R=0 whenever BLANK_N=0; HS edges shift with L=4.
//  5 en toggled 1,0,1,0: HS active 192 clk, line 1600 clk; all outputs hold while en=0.
//  6 rst pulsed 1 clk at v=200,h=300: next clk counters (0,0), oAddress 0, BLANK_N 0,
//    HS/VS inactive; next frame addresses again start at 0.

Source files
------------

// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA scan engine: raw h/v counters, framebuffer read addresses
// with optional square pixel replication, and a pipeline that delays sync and
// blank by the framebuffer read latency so colour, sync and blank leave aligned.
module vga_timing_gen_p #(
  parameter int   H_DISPLAY  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_DISPLAY  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   SCALE_LOG2 = 0,
  parameter int   RD_LAT     = 1,
  parameter int   COLOR_W    = 8,
  parameter int   ADDR_W     = 19,
  parameter int   CNT_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] R_in,
  input  logic [COLOR_W-1:0] G_in,
  input  logic [COLOR_W-1:0] B_in,
  output logic [ADDR_W-1:0]  oAddress,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               HS,
  output logic               VS,
  output logic               BLANK_N,
  output logic               VGA_SYNC,
  output logic               VGA_CLK,
  output logic [CNT_W-1:0]   h_pos,
  output logic [CNT_W-1:0]   v_pos,
  output logic               frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END     = CNT_W'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [CNT_W-1:0] H_ACT_LAST    = CNT_W'(H_SYNC + H_BACK + H_DISPLAY - 1);
  localparam logic [CNT_W-1:0] V_ACT_START   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END     = CNT_W'(V_SYNC + V_BACK + V_DISPLAY);
  localparam logic [CNT_W-1:0] Y_LAST        = CNT_W'(V_DISPLAY - 1);
  localparam logic [CNT_W-1:0] ROW_MASK      = CNT_W'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] FB_W_STEP    = ADDR_W'(H_DISPLAY >> SCALE_LOG2);

  logic               h_active;
  logic               v_active;
  logic               active0;
  logic               hs0;
  logic               vs0;
  logic [CNT_W-1:0]   x_off;
  logic [CNT_W-1:0]   y_off;
  logic [CNT_W-1:0]   x_scaled;
  logic [ADDR_W-1:0]  line_base;
  logic [RD_LAT:0]    active_sr;
  logic [RD_LAT:0]    hs_sr;
  logic [RD_LAT:0]    vs_sr;

  assign VGA_SYNC = 1'b1;
  assign VGA_CLK  = clk;

  // Stage-0 decode of the raw counters: active window, syncs and pixel offsets
  always_comb begin
    h_active    = (h_pos >= H_ACT_START) && (h_pos < H_ACT_END);
    v_active    = (v_pos >= V_ACT_START) && (v_pos < V_ACT_END);
    active0     = h_active && v_active;
    hs0         = (h_pos < H_SYNC_END) ? HS_POL : ~HS_POL;
    vs0         = (v_pos < V_SYNC_END) ? VS_POL : ~VS_POL;
    x_off       = h_pos - H_ACT_START;
    y_off       = v_pos - V_ACT_START;
    x_scaled    = x_off >> SCALE_LOG2;
    frame_start = en && !rst && (h_pos == '0) && (v_pos == '0);
  end

  // Scan counters: h wraps at line end and carries into v, which wraps at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_pos <= '0;
      v_pos <= '0;
    end else if (en) begin
      if (h_pos == H_LAST) begin
        h_pos <= '0;
        v_pos <= (v_pos == V_LAST) ? '0 : v_pos + CNT_ONE;
      end else begin
        h_pos <= h_pos + CNT_ONE;
      end
    end
  end

  // Read address = row base + scaled column; the base steps by one framebuffer
  // row after the last replicated line of each row, and returns to 0 after the
  // last active line so the next frame starts at address 0 without a multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      oAddress  <= '0;
      line_base <= '0;
    end else if (en && active0) begin
      oAddress <= line_base + ADDR_W'(x_scaled);
      if (h_pos == H_ACT_LAST) begin
        if (y_off == Y_LAST) begin
          line_base <= '0;
        end else if ((y_off & ROW_MASK) == ROW_MASK) begin
          line_base <= line_base + FB_W_STEP;
        end
      end
    end
  end

  // Delay active/sync by the address register plus the RAM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      active_sr <= '0;
      hs_sr     <= {(RD_LAT + 1){~HS_POL}};
      vs_sr     <= {(RD_LAT + 1){~VS_POL}};
    end else if (en) begin
      active_sr <= {active_sr[RD_LAT-1:0], active0};
      hs_sr     <= {hs_sr[RD_LAT-1:0], hs0};
      vs_sr     <= {vs_sr[RD_LAT-1:0], vs0};
    end
  end

  // Output register: colour passes only inside the active window
  always_ff @(posedge clk) begin
    if (rst) begin
      R       <= '0;
      G       <= '0;
      B       <= '0;
      BLANK_N <= 1'b0;
      HS      <= ~HS_POL;
      VS      <= ~VS_POL;
    end else if (en) begin
      BLANK_N <= active_sr[RD_LAT];
      HS      <= hs_sr[RD_LAT];
      VS      <= vs_sr[RD_LAT];
      R       <= active_sr[RD_LAT] ? R_in : '0;
      G       <= active_sr[RD_LAT] ? G_in : '0;
      B       <= active_sr[RD_LAT] ? B_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Bench for vga_timing_gen_p: two instances on a reduced raster (one plain,
// one with 2x replication, RD_LAT=2 and active-high syncs) checked every cycle
// against a step-count model, plus hand-computed literal checkpoints.
module tb_vga_timing_gen_p;

  localparam int HD = 16, HF = 2, HSY = 3, HB = 2;
  localparam int VD = 8,  VF = 1, VSY = 2, VB = 2;
  localparam int HT = HD + HF + HSY + HB;
  localparam int VT = VD + VF + VSY + VB;
  localparam int HAS = HSY + HB;
  localparam int VAS = VSY + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic check_on = 1'b0;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int exp_addr0 = 0;
  int exp_addr1 = 0;

  logic [18:0] addr0, addr1;
  logic [7:0]  r_in0, g_in0, b_in0, r_in1, g_in1, b_in1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, bn0, sync0, vclk0, fs0;
  logic        hs1, vs1, bn1, sync1, vclk1, fs1;
  logic [9:0]  hp0, vp0, hp1, vp1;
  logic [18:0] ram0_q, ram1_q1, ram1_q2;

  always #5 clk = ~clk;

  vga_timing_gen_p #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_LOG2(0), .RD_LAT(1)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .R_in(r_in0), .G_in(g_in0), .B_in(b_in0),
    .oAddress(addr0), .R(r0), .G(g0), .B(b0), .HS(hs0), .VS(vs0), .BLANK_N(bn0),
    .VGA_SYNC(sync0), .VGA_CLK(vclk0), .h_pos(hp0), .v_pos(vp0), .frame_start(fs0)
  );

  vga_timing_gen_p #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_LOG2(1), .RD_LAT(2)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .R_in(r_in1), .G_in(g_in1), .B_in(b_in1),
    .oAddress(addr1), .R(r1), .G(g1), .B(b1), .HS(hs1), .VS(vs1), .BLANK_N(bn1),
    .VGA_SYNC(sync1), .VGA_CLK(vclk1), .h_pos(hp1), .v_pos(vp1), .frame_start(fs1)
  );

  function automatic logic [7:0] col_r(input int a);
    return 8'(a);
  endfunction

  function automatic logic [7:0] col_g(input int a);
    return 8'(a * 3);
  endfunction

  function automatic logic [7:0] col_b(input int a);
    return 8'(a ^ 165);
  endfunction

  function automatic bit is_active(input int h, input int v);
    return (h >= HAS) && (h < HAS + HD) && (v >= VAS) && (v < VAS + VD);
  endfunction

  function automatic int model_addr(input int h, input int v, input int s);
    return ((v - VAS) >> s) * (HD >> s) + ((h - HAS) >> s);
  endfunction

  // Framebuffer RAM models: data is a fixed function of the address, RD_LAT steps late
  always @(posedge clk) begin
    if (en) begin
      ram0_q  <= addr0;
      ram1_q1 <= addr1;
      ram1_q2 <= ram1_q1;
    end
  end

  assign r_in0 = col_r(int'(ram0_q));
  assign g_in0 = col_g(int'(ram0_q));
  assign b_in0 = col_b(int'(ram0_q));
  assign r_in1 = col_r(int'(ram1_q2));
  assign g_in1 = col_g(int'(ram1_q2));
  assign b_in1 = col_b(int'(ram1_q2));

  // Model: n counts en-steps since reset; remember the address of the last active step
  always @(posedge clk) begin
    if (rst) begin
      n         <= 0;
      exp_addr0 <= 0;
      exp_addr1 <= 0;
    end else if (en) begin
      if (is_active(n % HT, (n / HT) % VT)) begin
        exp_addr0 <= model_addr(n % HT, (n / HT) % VT, 0);
        exp_addr1 <= model_addr(n % HT, (n / HT) % VT, 1);
      end
      n <= n + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic checkDut(input string tag, input int s, input int lat, input logic pol,
                          input int eaddr, input logic [18:0] addr,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic hs, input logic vs, input logic bn,
                          input logic [9:0] hp, input logic [9:0] vp, input logic fs,
                          input logic syn);
    int k, h, v, a;
    bit act;
    logic ehs, evs;
    act = 1'b0;
    ehs = ~pol;
    evs = ~pol;
    a = 0;
    if (n >= lat) begin
      k   = n - lat;
      h   = k % HT;
      v   = (k / HT) % VT;
      act = is_active(h, v);
      ehs = (h < HSY) ? pol : ~pol;
      evs = (v < VSY) ? pol : ~pol;
      if (act) a = model_addr(h, v, s);
    end
    checkOutput({tag, "_h_pos"}, hp, n % HT);
    checkOutput({tag, "_v_pos"}, vp, (n / HT) % VT);
    checkOutput({tag, "_frame_start"}, fs, en && !rst && (n % HT == 0) && ((n / HT) % VT == 0));
    checkOutput({tag, "_addr"}, addr, eaddr);
    checkOutput({tag, "_blank_n"}, bn, act);
    checkOutput({tag, "_hs"}, hs, ehs);
    checkOutput({tag, "_vs"}, vs, evs);
    checkOutput({tag, "_r"}, r, act ? col_r(a) : 8'h00);
    checkOutput({tag, "_g"}, g, act ? col_g(a) : 8'h00);
    checkOutput({tag, "_b"}, b, act ? col_b(a) : 8'h00);
    checkOutput({tag, "_vga_sync"}, syn, 1'b1);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (check_on) begin
      checkDut("d0", 0, 3, 1'b0, exp_addr0, addr0, r0, g0, b0, hs0, vs0, bn0, hp0, vp0, fs0, sync0);
      checkDut("d1", 1, 4, 1'b1, exp_addr1, addr1, r1, g1, b1, hs1, vs1, bn1, hp1, vp1, fs1, sync1);
    end
  end

  task automatic applyStimulus(input logic r, input logic e);
    @(posedge clk);
    #1;
    rst = r;
    en  = e;
  endtask

  task automatic waitPos(input int h, input int v, input int budget, input string name);
    int c = 0;
    while (!(int'(hp0) == h && int'(vp0) == v) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: position (%0d,%0d) not reached within %0d cycles", name, h, v, budget);
    end
  endtask

  initial begin
    int cnt;
    int guard;
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1 check_on = 1'b1;
    repeat (2) @(posedge clk);

    // Release reset; syncs must turn active exactly L steps later
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("hs0_before_L", hs0, 1'b1);
    checkOutput("hs1_before_L", hs1, 1'b0);
    @(negedge clk);
    checkOutput("hs0_at_L3", hs0, 1'b0);
    checkOutput("hs1_before_L4", hs1, 1'b0);
    @(negedge clk);
    checkOutput("hs1_at_L4", hs1, 1'b1);

    // Address checkpoints through the first frame and into the second
    waitPos(6, 4, 400, "wait_first_pixel");
    checkOutput("d0_first_addr", addr0, 0);
    checkOutput("d1_first_addr", addr1, 0);
    waitPos(7, 6, 400, "wait_row1_scaled");
    checkOutput("d1_row1_addr", addr1, 8);
    waitPos(21, 11, 400, "wait_last_pixel");
    checkOutput("d0_last_addr", addr0, 127);
    checkOutput("d1_last_addr", addr1, 31);
    waitPos(22, 12, 400, "wait_frame_end");
    checkOutput("d0_hold_addr", addr0, 127);
    waitPos(0, 0, 400, "wait_frame_wrap");
    checkOutput("d0_frame_start", fs0, 1'b1);
    waitPos(6, 4, 400, "wait_second_frame");
    checkOutput("d0_wrap_addr", addr0, 0);
    checkOutput("d1_wrap_addr", addr1, 0);

    // en toggling: every step takes two clocks, so the HS pulse doubles
    fork
      begin
        repeat (700) applyStimulus(1'b0, ~en);
      end
      begin
        guard = 0;
        cnt   = 0;
        while (hs0 !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
        while (hs0 !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
        while (hs0 === 1'b0 && guard < 400) begin cnt++; @(negedge clk); guard++; end
        checkOutput("hs_active_half_rate", cnt, 6);
      end
    join
    applyStimulus(1'b0, 1'b1);

    // Mid-frame reset pulse
    waitPos(10, 6, 400, "wait_mid_frame");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_h_pos", hp0, 0);
    checkOutput("rst_v_pos", vp0, 0);
    checkOutput("rst_addr", addr0, 0);
    checkOutput("rst_blank_n", bn0, 1'b0);
    checkOutput("rst_hs0", hs0, 1'b1);
    checkOutput("rst_hs1", hs1, 1'b0);
    waitPos(6, 4, 400, "wait_after_reset");
    checkOutput("d0_addr_after_reset", addr0, 0);
    repeat (320) @(negedge clk);

    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
